// File: rtl/osc_window_ctrl.sv
// osc_window_ctrl: counts ring-oscillator edges per timer window and steps the DAC code toward a target
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   en            1 = run the loop, 0 = idle with ctrl_code held at CODE_INIT
//   osc_in        raw oscillator output (asynchronous, below clk/2)
//   count_done    window-end strobe from the window timer
//   target_count  desired edges per window, sampled during evaluation
//   osc_count     edges counted in the last completed window
//   meas_valid    one-cycle pulse when osc_count updates
//   ctrl_code     current-source DAC code (higher = faster oscillator)
//   lock          asserted after LOCK_WIN consecutive in-tolerance windows
//   cnt_ovf       only with CNT_OVF_EN: last window's edge counter saturated
//
// Build option: define CNT_OVF_EN to add cnt_ovf and skip code steps on saturated windows.
module osc_window_ctrl #(
    parameter int CNT_W     = 16,
    parameter int CODE_W    = 6,
    parameter int CODE_INIT = 32,
    parameter int LOCK_TOL  = 2,
    parameter int LOCK_WIN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              osc_in,
    input  logic              count_done,
    input  logic [CNT_W-1:0]  target_count,
    output logic [CNT_W-1:0]  osc_count,
    output logic              meas_valid,
    output logic [CODE_W-1:0] ctrl_code,
`ifdef CNT_OVF_EN
    output logic              cnt_ovf,
`endif
    output logic              lock
);
    localparam int RUN_W = $clog2(LOCK_WIN + 1);
    localparam logic [CNT_W-1:0]         CNT_MAX  = '1;
    localparam logic [CODE_W-1:0]        CODE_MAX = '1;
    localparam logic [CODE_W-1:0]        INIT     = CODE_W'(CODE_INIT);
    localparam logic [RUN_W-1:0]         WIN      = RUN_W'(LOCK_WIN);
    localparam logic signed [CNT_W:0]    TOL      = (CNT_W + 1)'(LOCK_TOL);

    typedef enum logic [1:0] {IDLE, RUN, EVAL} state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_q, sync_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]    osc_count_q, osc_count_d;
    logic                meas_valid_q, meas_valid_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                lock_q, lock_d;
    logic                osc_edge, win_sat, in_tol;
    logic signed [CNT_W:0] diff;
`ifdef CNT_OVF_EN
    logic                ovf_q, ovf_d;
    assign cnt_ovf = ovf_q;
`endif

    // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the previous sample for edge detect
    assign osc_edge   = sync_q[1] & ~sync_q[2];
    assign osc_count  = osc_count_q;
    assign meas_valid = meas_valid_q;
    assign ctrl_code  = code_q;
    assign lock       = lock_q;

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[1:0], osc_in};
        cnt_d        = cnt_q;
        osc_count_d  = osc_count_q;
        meas_valid_d = 1'b0;
        code_d       = code_q;
        run_d        = run_q;
        lock_d       = lock_q;
        win_sat      = 1'b0;
`ifdef CNT_OVF_EN
        ovf_d        = ovf_q;
        win_sat      = ovf_q;
`endif
        cnt_inc = (osc_edge && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
        diff    = $signed({1'b0, osc_count_q}) - $signed({1'b0, target_count});
        in_tol  = !win_sat && diff >= -TOL && diff <= TOL;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            code_d  = INIT;
            run_d   = '0;
            lock_d  = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_inc;
            if (count_done) begin
                // the edge detected in the closing cycle still belongs to this window
                state_d      = EVAL;
                osc_count_d  = cnt_inc;
                cnt_d        = '0;
                meas_valid_d = 1'b1;
`ifdef CNT_OVF_EN
                ovf_d        = cnt_inc == CNT_MAX;
`endif
            end
        end else begin
            // edges seen while evaluating start the next window's count
            state_d = RUN;
            cnt_d   = cnt_inc;
            if (in_tol) begin
                run_d  = (run_q == WIN) ? WIN : run_q + RUN_W'(1);
                lock_d = run_d == WIN;
            end else begin
                run_d  = '0;
                lock_d = 1'b0;
                if (!win_sat && diff > TOL && code_q != '0)
                    code_d = code_q - CODE_W'(1);
                else if (!win_sat && diff < -TOL && code_q != CODE_MAX)
                    code_d = code_q + CODE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            cnt_q        <= '0;
            osc_count_q  <= '0;
            meas_valid_q <= 1'b0;
            code_q       <= INIT;
            run_q        <= '0;
            lock_q       <= 1'b0;
`ifdef CNT_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            osc_count_q  <= osc_count_d;
            meas_valid_q <= meas_valid_d;
            code_q       <= code_d;
            run_q        <= run_d;
            lock_q       <= lock_d;
`ifdef CNT_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_osc_window_ctrl.sv
// tb_osc_window_ctrl: directed self-checking bench for osc_window_ctrl
module tb_osc_window_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        osc_in = 1'b0;
    logic        count_done = 1'b0;
    logic [15:0] target_count = '0;
    logic [15:0] osc_count;
    logic        meas_valid;
    logic [5:0]  ctrl_code;
    logic        lock;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    osc_window_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .osc_in(osc_in), .count_done(count_done),
        .target_count(target_count), .osc_count(osc_count), .meas_valid(meas_valid),
`ifdef CNT_OVF_EN
        .cnt_ovf(),
`endif
        .ctrl_code(ctrl_code), .lock(lock)
    );

`ifdef CNT_OVF_EN
    logic       en_o = 1'b0;
    logic [3:0] target_o = '0;
    logic [3:0] osc_count_o;
    logic       meas_valid_o, lock_o, cnt_ovf_o;
    logic [5:0] ctrl_code_o;
    osc_window_ctrl #(.CNT_W(4)) u_ovf (
        .clk(clk), .rst_n(rst_n), .en(en_o), .osc_in(osc_in), .count_done(count_done),
        .target_count(target_o), .osc_count(osc_count_o), .meas_valid(meas_valid_o),
        .cnt_ovf(cnt_ovf_o), .ctrl_code(ctrl_code_o), .lock(lock_o)
    );
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_edges(input int n);
        for (int i = 0; i < n; i++) begin
            osc_in = 1'b1;
            tick();
            osc_in = 1'b0;
            tick();
            tick();
        end
    endtask

    // n edges then a one-cycle count_done; returns during the EVAL cycle
    task automatic run_window(input int n);
        gen_edges(n);
        count_done = 1'b1;
        tick();
        count_done = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++; if (osc_count !== 16'd0) begin errors++; $display("FAIL rst osc_count got=%0d exp=0", osc_count); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rst meas_valid got=%0d exp=0", meas_valid); end
        checks++; if (ctrl_code !== 6'd32) begin errors++; $display("FAIL rst ctrl_code got=%0d exp=32", ctrl_code); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL rst lock got=%0d exp=0", lock); end
        rst_n = 1'b1;
        en = 1'b1;
        target_count = 16'd0;
        tick();
        run_window(10);
        checks++; if (osc_count !== 16'd10) begin errors++; $display("FAIL rst_win osc_count got=%0d exp=10", osc_count); end
        tick();
        checks++; if (ctrl_code !== 6'd31) begin errors++; $display("FAIL rst_win ctrl_code got=%0d exp=31", ctrl_code); end
        gen_edges(3);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (osc_count !== 16'd0) begin errors++; $display("FAIL async_rst osc_count got=%0d exp=0", osc_count); end
        checks++; if (ctrl_code !== 6'd32) begin errors++; $display("FAIL async_rst ctrl_code got=%0d exp=32", ctrl_code); end
        checks++; if (lock !== 1'b0 || meas_valid !== 1'b0) begin errors++; $display("FAIL async_rst lock/mv got=%0d/%0d exp=0/0", lock, meas_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        run_window(2);
        checks++; if (osc_count !== 16'd2) begin errors++; $display("FAIL post_rst osc_count got=%0d exp=2", osc_count); end
        tick();
        checks++; if (ctrl_code !== 6'd32) begin errors++; $display("FAIL post_rst ctrl_code got=%0d exp=32", ctrl_code); end
    endtask

    task automatic test_step_down;
        target_count = 16'd100;
        for (int i = 0; i < 3; i++) begin
            run_window(120);
            checks++; if (meas_valid !== 1'b1 || osc_count !== 16'd120) begin errors++; $display("FAIL down%0d mv/osc got=%0d/%0d exp=1/120", i, meas_valid, osc_count); end
            checks++; if (ctrl_code !== 6'(32 - i)) begin errors++; $display("FAIL down%0d eval_code got=%0d exp=%0d", i, ctrl_code, 32 - i); end
            tick();
            checks++; if (ctrl_code !== 6'(31 - i) || meas_valid !== 1'b0) begin errors++; $display("FAIL down%0d code/mv got=%0d/%0d exp=%0d/0", i, ctrl_code, meas_valid, 31 - i); end
        end
    endtask

    task automatic test_lock;
        for (int i = 0; i < 4; i++) begin
            run_window(99);
            tick();
            checks++; if (ctrl_code !== 6'd29 || lock !== (i == 3)) begin errors++; $display("FAIL lock%0d code/lock got=%0d/%0d exp=29/%0d", i, ctrl_code, lock, i == 3); end
        end
        run_window(90);
        tick();
        checks++; if (ctrl_code !== 6'd30 || lock !== 1'b0) begin errors++; $display("FAIL unlock code/lock got=%0d/%0d exp=30/0", ctrl_code, lock); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 35; i++) begin
            run_window(0);
            tick();
        end
        checks++; if (ctrl_code !== 6'd63) begin errors++; $display("FAIL sat_hi ctrl_code got=%0d exp=63", ctrl_code); end
        target_count = 16'd0;
        run_window(3);
        tick();
        checks++; if (ctrl_code !== 6'd62) begin errors++; $display("FAIL first_down ctrl_code got=%0d exp=62", ctrl_code); end
        for (int i = 0; i < 64; i++) begin
            run_window(3);
            tick();
        end
        checks++; if (ctrl_code !== 6'd0) begin errors++; $display("FAIL sat_lo ctrl_code got=%0d exp=0", ctrl_code); end
    endtask

    task automatic test_edge_timing;
        target_count = 16'd2;
        gen_edges(2);
        osc_in = 1'b1;
        tick();
        osc_in = 1'b0;
        tick();
        count_done = 1'b1;
        tick();
        count_done = 1'b0;
        checks++; if (meas_valid !== 1'b1 || osc_count !== 16'd3) begin errors++; $display("FAIL same_cycle mv/osc got=%0d/%0d exp=1/3", meas_valid, osc_count); end
        tick();
        gen_edges(1);
        osc_in = 1'b1;
        tick();
        osc_in = 1'b0;
        count_done = 1'b1;
        tick();
        count_done = 1'b0;
        checks++; if (osc_count !== 16'd1) begin errors++; $display("FAIL eval_edge osc_count got=%0d exp=1", osc_count); end
        tick();
        run_window(1);
        checks++; if (osc_count !== 16'd2) begin errors++; $display("FAIL carry_edge osc_count got=%0d exp=2", osc_count); end
        tick();
    endtask

    task automatic test_back_to_back;
        target_count = 16'd0;
        count_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (meas_valid !== (i % 2 == 0)) begin errors++; $display("FAIL stuck%0d meas_valid got=%0d exp=%0d", i, meas_valid, i % 2 == 0); end
        end
        checks++; if (lock !== 1'b1 || ctrl_code !== 6'd0) begin errors++; $display("FAIL stuck lock/code got=%0d/%0d exp=1/0", lock, ctrl_code); end
        count_done = 1'b0;
        target_count = 16'd4;
        run_window(4);
        checks++; if (osc_count !== 16'd4) begin errors++; $display("FAIL pre_idle osc_count got=%0d exp=4", osc_count); end
        tick();
        en = 1'b0;
        tick();
        checks++; if (ctrl_code !== 6'd32 || lock !== 1'b0) begin errors++; $display("FAIL idle code/lock got=%0d/%0d exp=32/0", ctrl_code, lock); end
        checks++; if (osc_count !== 16'd4) begin errors++; $display("FAIL idle osc_count got=%0d exp=4", osc_count); end
    endtask

    task automatic test_idle_clear;
        gen_edges(2);
        en = 1'b1;
        tick();
        run_window(1);
        checks++; if (osc_count !== 16'd1) begin errors++; $display("FAIL idle_clear osc_count got=%0d exp=1", osc_count); end
        tick();
        checks++; if (ctrl_code !== 6'd33) begin errors++; $display("FAIL restart ctrl_code got=%0d exp=33", ctrl_code); end
    endtask

`ifdef CNT_OVF_EN
    task automatic test_ovf;
        en_o = 1'b1;
        target_o = 4'd4;
        tick();
        run_window(20);
        checks++; if (osc_count_o !== 4'd15 || cnt_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf osc/ovf got=%0d/%0d exp=15/1", osc_count_o, cnt_ovf_o); end
        tick();
        checks++; if (ctrl_code_o !== 6'd32) begin errors++; $display("FAIL ovf_hold ctrl_code got=%0d exp=32", ctrl_code_o); end
        run_window(3);
        checks++; if (osc_count_o !== 4'd3 || cnt_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear osc/ovf got=%0d/%0d exp=3/0", osc_count_o, cnt_ovf_o); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_step_down();
        test_lock();
        test_saturation();
        test_edge_timing();
        test_back_to_back();
        test_idle_clear();
`ifdef CNT_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
